// File: rtl/wall_column_feeder.sv
// Map-driven wall column source: expands run-length ROM records into column bitmaps on request.
// Define WALL_FEEDER_MAP_LOOP_EN to wrap the map at its end marker instead of stopping.
module wall_column_feeder #(
    parameter int ADDR_W = 10,
    parameter int COL_H  = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              col_req,
    output logic              col_valid,
    output logic [COL_H-1:0]  col_data,
    output logic              col_solid,
    output logic              map_end,
    output logic              overrun,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data
);

    typedef enum logic [2:0] {
        S_FETCH_B,
        S_FETCH_T,
        S_FETCH_R,
        S_LOAD,
        S_READY,
        S_END
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [7:0]        b_reg;
    logic [7:0]        t_reg;
    logic [7:0]        remaining;
    logic              pending;
    logic              serve;
    logic [COL_H-1:0]  col_next;
    logic [8:0]        height_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH_B;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (restart) begin
            state_next = S_FETCH_B;
        end else begin
            case (state)
                S_FETCH_B: state_next = S_FETCH_T;
                S_FETCH_T: state_next = S_FETCH_R;
                S_FETCH_R: state_next = S_LOAD;
                S_LOAD:    state_next = (rom_data == 8'd0) ? S_END : S_READY;
                S_READY: begin
                    if (serve && remaining == 8'd1) begin
                        state_next = S_FETCH_B;
                    end
                end
                S_END: begin
`ifdef WALL_FEEDER_MAP_LOOP_EN
                    state_next = S_FETCH_B;
`else
                    state_next = S_END;
`endif
                end
                default: state_next = S_FETCH_B;
            endcase
        end
    end

    // ROM address follows the fetch step; the ROM returns each byte one cycle later.
    always_comb begin
        rom_addr = base;
        serve    = 1'b0;
        case (state)
            S_FETCH_T: rom_addr = base + ADDR_W'(1);
            S_FETCH_R: rom_addr = base + ADDR_W'(2);
            S_READY:   serve = !restart && (col_req || pending);
            S_END: begin
`ifdef WALL_FEEDER_MAP_LOOP_EN
                serve = 1'b0;
`else
                serve = !restart && (col_req || pending);
`endif
            end
            default: begin
                rom_addr = base;
                serve    = 1'b0;
            end
        endcase
    end

    // Overlapping walls, or a floor taller than the column, collapse to a solid column.
    always_comb begin
        col_next   = '0;
        height_sum = {1'b0, b_reg} + {1'b0, t_reg};
        if ({1'b0, b_reg} >= 9'(COL_H) || height_sum >= 9'(COL_H)) begin
            col_next = '1;
        end else begin
            for (int k = 0; k < COL_H; k++) begin
                if (9'(k) < {1'b0, b_reg} || 9'(k) >= 9'(COL_H) - {1'b0, t_reg}) begin
                    col_next[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_valid <= 1'b0;
            col_data  <= '0;
            col_solid <= 1'b0;
            map_end   <= 1'b0;
            overrun   <= 1'b0;
            base      <= '0;
            b_reg     <= '0;
            t_reg     <= '0;
            remaining <= '0;
            pending   <= 1'b0;
        end else begin
            col_valid <= 1'b0;
            if (restart) begin
                base      <= '0;
                pending   <= 1'b0;
                map_end   <= 1'b0;
                overrun   <= 1'b0;
                remaining <= '0;
            end else begin
                if (col_req && pending) begin
                    overrun <= 1'b1;
                end
                if (serve) begin
                    pending <= 1'b0;
                end else if (col_req) begin
                    pending <= 1'b1;
                end
                case (state)
                    S_FETCH_T: b_reg <= rom_data;
                    S_FETCH_R: t_reg <= rom_data;
                    S_LOAD: begin
                        remaining <= rom_data;
                        base      <= base + ADDR_W'(3);
                    end
                    S_READY: begin
                        if (serve) begin
                            col_valid <= 1'b1;
                            col_data  <= col_next;
                            col_solid <= |col_next;
                            remaining <= remaining - 8'd1;
                        end
                    end
                    S_END: begin
`ifdef WALL_FEEDER_MAP_LOOP_EN
                        base <= '0;
`else
                        map_end <= 1'b1;
                        if (serve) begin
                            col_valid <= 1'b1;
                            col_data  <= '0;
                            col_solid <= 1'b0;
                        end
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wall_column_feeder.sv
// Directed bench for wall_column_feeder: table of per-request vectors plus hand-written
// sequences for refetch/overrun, restart and mid-fetch reset. Honours WALL_FEEDER_MAP_LOOP_EN.
module tb_wall_column_feeder;

    localparam int ADDR_W = 10;
    localparam int COL_H  = 100;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              restart = 1'b0;
    logic              col_req = 1'b0;
    logic              col_valid;
    logic [COL_H-1:0]  col_data;
    logic              col_solid;
    logic              map_end;
    logic              overrun;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data = 8'd0;

    logic [7:0] rom [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit               rst;
        int               rom_set;
        logic [COL_H-1:0] data;
        bit               solid;
        bit               map_end;
    } vec_t;

    vec_t vecs [10];

    wall_column_feeder #(.ADDR_W(ADDR_W), .COL_H(COL_H)) dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .col_req   (col_req),
        .col_valid (col_valid),
        .col_data  (col_data),
        .col_solid (col_solid),
        .map_end   (map_end),
        .overrun   (overrun),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [COL_H-1:0] band(input int lo, input int hi);
        logic [COL_H-1:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [COL_H-1:0] act,
                                input logic [COL_H-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_rom(input int set);
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'd0;
        if (set == 1) begin
            rom[0] = 8'd20; rom[1] = 8'd0;  rom[2] = 8'd3;
            rom[3] = 8'd0;  rom[4] = 8'd20; rom[5] = 8'd2;
        end else begin
            rom[0] = 8'd60; rom[1] = 8'd50; rom[2] = 8'd1;
            rom[3] = 8'd0;  rom[4] = 8'd0;  rom[5] = 8'd1;
            rom[6] = 8'd99; rom[7] = 8'd0;  rom[8] = 8'd1;
        end
    endtask

    task automatic do_reset();
        col_req = 1'b0;
        restart = 1'b0;
        reset   = 1'b1;
        tick();
        check_output("reset col_valid", COL_H'(col_valid), '0);
        check_output("reset col_data", col_data, '0);
        check_output("reset col_solid", COL_H'(col_solid), '0);
        check_output("reset map_end", COL_H'(map_end), '0);
        check_output("reset overrun", COL_H'(overrun), '0);
        check_output("reset rom_addr", COL_H'(rom_addr), '0);
        tick();
        reset = 1'b0;
    endtask

    // One request after an idle gap; checks latency, payload and single-cycle valid.
    task automatic apply_stimulus(input string name, input int gap, input logic [COL_H-1:0] exp_data,
                                  input bit exp_solid, input int exp_lat);
        int lat;
        repeat (gap) tick();
        col_req = 1'b1;
        tick();
        col_req = 1'b0;
        lat = 1;
        while (!col_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_output({name, " valid seen"}, COL_H'(col_valid), COL_H'(1));
        check_output({name, " latency"}, COL_H'(lat), COL_H'(exp_lat));
        check_output({name, " data"}, col_data, exp_data);
        check_output({name, " solid"}, COL_H'(col_solid), COL_H'(exp_solid));
        tick();
        check_output({name, " valid pulse"}, COL_H'(col_valid), '0);
    endtask

    initial begin
        int n_valid;
        int first;
        logic [COL_H-1:0] seen;

        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'd0;

        vecs[0] = '{1'b1, 1, band(0, 19),  1'b1, 1'b0};
        vecs[1] = '{1'b0, 1, band(0, 19),  1'b1, 1'b0};
        vecs[2] = '{1'b0, 1, band(0, 19),  1'b1, 1'b0};
        vecs[3] = '{1'b0, 1, band(80, 99), 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1, band(80, 99), 1'b1, 1'b0};
`ifdef WALL_FEEDER_MAP_LOOP_EN
        vecs[5] = '{1'b0, 1, band(0, 19),  1'b1, 1'b0};
`else
        vecs[5] = '{1'b0, 1, '0,           1'b0, 1'b1};
`endif
        vecs[6] = '{1'b1, 2, '1,           1'b1, 1'b0};
        vecs[7] = '{1'b0, 2, '0,           1'b0, 1'b0};
        vecs[8] = '{1'b0, 2, band(0, 98),  1'b1, 1'b0};
`ifdef WALL_FEEDER_MAP_LOOP_EN
        vecs[9] = '{1'b0, 2, '1,           1'b1, 1'b0};
`else
        vecs[9] = '{1'b0, 2, '0,           1'b0, 1'b1};
`endif

        repeat (2) tick();

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].rst) begin
                load_rom(vecs[v].rom_set);
                do_reset();
            end
            apply_stimulus($sformatf("vec%0d", v), 12, vecs[v].data, vecs[v].solid, 1);
            check_output($sformatf("vec%0d map_end", v), COL_H'(map_end), COL_H'(vecs[v].map_end));
        end

        // Request during a refetch, then a second one while it is still pending.
        load_rom(1);
        do_reset();
        apply_stimulus("ovr r1", 8, band(0, 19), 1'b1, 1);
        apply_stimulus("ovr r2", 2, band(0, 19), 1'b1, 1);
        apply_stimulus("ovr r3", 2, band(0, 19), 1'b1, 1);
        col_req = 1'b1;
        n_valid = 0;
        first   = 0;
        seen    = '0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            col_req = (c == 2);
            if (col_valid) begin
                n_valid++;
                if (first == 0) begin
                    first = c;
                    seen  = col_data;
                end
            end
        end
        check_output("refetch latency", COL_H'(first), COL_H'(4));
        check_output("overrun single valid", COL_H'(n_valid), COL_H'(1));
        check_output("refetch data", seen, band(80, 99));
        check_output("overrun flag", COL_H'(overrun), COL_H'(1));

        // Restart with a simultaneous request, midway through the second record.
        restart = 1'b1;
        col_req = 1'b1;
        tick();
        restart = 1'b0;
        col_req = 1'b0;
        check_output("restart no valid", COL_H'(col_valid), '0);
        check_output("restart rom_addr", COL_H'(rom_addr), '0);
        check_output("restart overrun clr", COL_H'(overrun), '0);
        n_valid = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (col_valid) n_valid++;
        end
        check_output("restart req dropped", COL_H'(n_valid), '0);
        apply_stimulus("post restart", 0, band(0, 19), 1'b1, 1);

        // Reset while the next record is in FETCH_T.
        apply_stimulus("pre reset a", 2, band(0, 19), 1'b1, 1);
        apply_stimulus("pre reset b", 2, band(0, 19), 1'b1, 1);
        check_output("fetch_t rom_addr", COL_H'(rom_addr), COL_H'(4));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("mid reset col_valid", COL_H'(col_valid), '0);
        check_output("mid reset col_data", col_data, '0);
        check_output("mid reset col_solid", COL_H'(col_solid), '0);
        check_output("mid reset map_end", COL_H'(map_end), '0);
        check_output("mid reset overrun", COL_H'(overrun), '0);
        check_output("mid reset rom_addr", COL_H'(rom_addr), '0);
        apply_stimulus("after reset", 8, band(0, 19), 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
